// File: rtl/dmem_port.sv
// Data-memory responder: services execute-stage loads/stores against a single-port
// synchronous word RAM, with read-modify-write for sub-word stores and load extension.
module dmem_port #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r_mem_enable_i,
    input  logic [31:0]           r_mem_addr_i,
    input  logic                  w_mem_enable_i,
    input  logic [31:0]           w_mem_addr_i,
    input  logic [31:0]           w_mem_data_i,
    input  logic [2:0]            data_type_i,
    output logic                  stall_o,
    output logic [31:0]           r_mem_data_o,
    output logic                  r_mem_valid_o,
    output logic                  misalign_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    // Access-type codes shared with the execute stage (RISC-V funct3 layout).
    localparam logic [2:0] DT_BYTE  = 3'b000;
    localparam logic [2:0] DT_HALF  = 3'b001;
    localparam logic [2:0] DT_WORD  = 3'b010;
    localparam logic [2:0] DT_UBYTE = 3'b100;
    localparam logic [2:0] DT_UHALF = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        RMW_MERGE
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] word_addr_q;
    logic [1:0]            offset_q;
    logic [2:0]            type_q;
    logic [15:0]           data_q;
    logic                  latch_en;

    logic        is_store, is_load;
    logic [31:0] req_addr;
    logic        size_byte, size_half, size_word, misaligned;
    logic        unused_addr_bits;

    assign is_store  = w_mem_enable_i;
    assign is_load   = !w_mem_enable_i && r_mem_enable_i;
    assign req_addr  = is_store ? w_mem_addr_i : r_mem_addr_i;
    assign size_byte = (data_type_i == DT_BYTE) || (data_type_i == DT_UBYTE);
    assign size_half = (data_type_i == DT_HALF) || (data_type_i == DT_UHALF);
    // Any unrecognised code is handled as a full word.
    assign size_word = !size_byte && !size_half;
    assign misaligned = (size_half && req_addr[0]) || (size_word && (req_addr[1:0] != 2'b00));

    // Byte-address bits above the RAM range alias by truncation.
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [2:0]  dtype);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (dtype)
            DT_BYTE:  return {{24{b[7]}}, b};
            DT_UBYTE: return {24'h0, b};
            DT_HALF:  return {{16{h[15]}}, h};
            DT_UHALF: return {16'h0, h};
            default:  return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [2:0]  dtype,
                                                input logic [15:0] data);
        logic [31:0] merged;
        merged = word;
        if ((dtype == DT_BYTE) || (dtype == DT_UBYTE))
            merged[{offset, 3'b000} +: 8] = data[7:0];
        else if (offset[1])
            merged[31:16] = data;
        else
            merged[15:0] = data;
        return merged;
    endfunction

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next    = state;
        latch_en      = 1'b0;
        stall_o       = 1'b0;
        r_mem_data_o  = 32'h0;
        r_mem_valid_o = 1'b0;
        misalign_o    = 1'b0;
        ram_en_o      = 1'b0;
        ram_we_o      = 1'b0;
        ram_addr_o    = '0;
        ram_wdata_o   = 32'h0;
        case (state)
            IDLE: begin
                if (is_store || is_load) begin
                    if (misaligned) begin
                        misalign_o = 1'b1;
                    end else if (is_store && size_word) begin
                        ram_en_o    = 1'b1;
                        ram_we_o    = 1'b1;
                        ram_addr_o  = req_addr[ADDR_WIDTH+1:2];
                        ram_wdata_o = w_mem_data_i;
                    end else begin
                        // Loads and sub-word stores both begin with a read of the word.
                        ram_en_o   = 1'b1;
                        ram_addr_o = req_addr[ADDR_WIDTH+1:2];
                        stall_o    = 1'b1;
                        latch_en   = 1'b1;
                        state_next = is_store ? RMW_MERGE : LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                r_mem_valid_o = 1'b1;
                r_mem_data_o  = extend_load(ram_rdata_i, offset_q, type_q);
                state_next    = IDLE;
            end
            RMW_MERGE: begin
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = word_addr_q;
                ram_wdata_o = merge_store(ram_rdata_i, offset_q, type_q, data_q);
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            word_addr_q <= '0;
            offset_q    <= 2'b00;
            type_q      <= 3'b000;
            data_q      <= 16'h0;
        end else begin
            state <= state_next;
            if (latch_en) begin
                word_addr_q <= req_addr[ADDR_WIDTH+1:2];
                offset_q    <= req_addr[1:0];
                type_q      <= data_type_i;
                data_q      <= w_mem_data_i[15:0];
            end
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: a table of single transactions against a behavioural
// RAM, plus hand-written sequences for back-to-back stores and reset during RMW.
module tb_dmem_port;

    localparam int AW = 12;

    localparam logic [2:0] DT_BYTE  = 3'b000;
    localparam logic [2:0] DT_HALF  = 3'b001;
    localparam logic [2:0] DT_WORD  = 3'b010;
    localparam logic [2:0] DT_UBYTE = 3'b100;
    localparam logic [2:0] DT_UHALF = 3'b101;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r_en, w_en;
    logic [31:0]   r_addr, w_addr, w_data;
    logic [2:0]    dtype;
    logic          stall, r_valid, misalign, ram_en, ram_we;
    logic [31:0]   r_data, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dmem_port #(.ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .r_mem_enable_i (r_en),
        .r_mem_addr_i   (r_addr),
        .w_mem_enable_i (w_en),
        .w_mem_addr_i   (w_addr),
        .w_mem_data_i   (w_data),
        .data_type_i    (dtype),
        .stall_o        (stall),
        .r_mem_data_o   (r_data),
        .r_mem_valid_o  (r_valid),
        .misalign_o     (misalign),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    // Behavioural single-port RAM with a bench-side preload port.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = 32'h0;
    int unsigned   wr_count = 0;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_count      <= wr_count + 1;
            end else
                ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        string       name;
        logic        w_en;
        logic        r_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  dt;
        logic        pre;
        logic [31:0] pre_word;
        logic        exp_stall;
        logic        exp_mis;
        logic [31:0] exp_rdata;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        w_en = 1'b0; r_en = 1'b0; w_addr = 32'h0; r_addr = 32'h0; w_data = 32'h0; dtype = DT_WORD;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [AW-1:0] word;
        logic          we_now, is_load;
        int unsigned   wr_before;
        word    = v.addr[AW+1:2];
        we_now  = v.w_en && !v.exp_mis && !v.exp_stall;
        is_load = !v.w_en && v.r_en;
        if (v.pre) preload(word, v.pre_word);
        @(posedge clk); #1;
        wr_before = wr_count;
        w_en = v.w_en; r_en = v.r_en; w_data = v.wdata; dtype = v.dt;
        w_addr = v.addr;
        r_addr = v.w_en ? (v.addr ^ 32'h30) : v.addr;
        @(negedge clk);
        check({v.name, " stall"},    {31'h0, stall},    {31'h0, v.exp_stall});
        check({v.name, " misalign"}, {31'h0, misalign}, {31'h0, v.exp_mis});
        check({v.name, " ram_en"},   {31'h0, ram_en},   {31'h0, !v.exp_mis});
        check({v.name, " ram_we"},   {31'h0, ram_we},   {31'h0, we_now});
        check({v.name, " valid_n"},  {31'h0, r_valid},  32'h0);
        if (!v.exp_mis) check({v.name, " ram_addr_n"}, {20'h0, ram_addr}, {20'h0, word});
        if (we_now) check({v.name, " wdata_n"}, ram_wdata, v.exp_word);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check({v.name, " misalign_n1"}, {31'h0, misalign}, 32'h0);
        check({v.name, " stall_n1"},    {31'h0, stall},    32'h0);
        if (is_load && !v.exp_mis) begin
            check({v.name, " valid_n1"}, {31'h0, r_valid}, 32'h1);
            check({v.name, " rdata"},    r_data,           v.exp_rdata);
        end else if (v.exp_stall) begin
            check({v.name, " ram_we_n1"}, {31'h0, ram_we}, 32'h1);
            check({v.name, " merged"},    ram_wdata,       v.exp_word);
            check({v.name, " ram_addr_n1"}, {20'h0, ram_addr}, {20'h0, word});
        end else begin
            check({v.name, " ram_en_n1"}, {31'h0, ram_en},  32'h0);
            check({v.name, " valid_n1"},  {31'h0, r_valid}, 32'h0);
        end
        @(posedge clk); #1;
        check({v.name, " mem"}, mem[word], v.exp_word);
        check({v.name, " writes"}, wr_count - wr_before,
              (we_now || (v.w_en && v.exp_stall)) ? 32'd1 : 32'd0);
    endtask

    initial begin
        //                 name       w  r  addr          wdata         dt        pre pre_word      stall mis  rdata         word
        vecs.push_back(vec_t'{"st_word",  1, 0, 32'h10,   32'hDEADBEEF, DT_WORD,  0, 32'h0,        0, 0, 32'h0,        32'hDEADBEEF});
        vecs.push_back(vec_t'{"ld_word",  0, 1, 32'h10,   32'h0,        DT_WORD,  0, 32'h0,        1, 0, 32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back(vec_t'{"st_byte",  1, 1, 32'h12,   32'hFFFFFFAB, DT_BYTE,  1, 32'h11223344, 1, 0, 32'h0,        32'h11AB3344});
        vecs.push_back(vec_t'{"ld_sb11",  0, 1, 32'h11,   32'h0,        DT_BYTE,  1, 32'h8000FF7F, 1, 0, 32'hFFFFFFFF, 32'h8000FF7F});
        vecs.push_back(vec_t'{"ld_ub11",  0, 1, 32'h11,   32'h0,        DT_UBYTE, 0, 32'h0,        1, 0, 32'h000000FF, 32'h8000FF7F});
        vecs.push_back(vec_t'{"ld_sh12",  0, 1, 32'h12,   32'h0,        DT_HALF,  0, 32'h0,        1, 0, 32'hFFFF8000, 32'h8000FF7F});
        vecs.push_back(vec_t'{"ld_uh12",  0, 1, 32'h12,   32'h0,        DT_UHALF, 0, 32'h0,        1, 0, 32'h00008000, 32'h8000FF7F});
        vecs.push_back(vec_t'{"ld_sb10",  0, 1, 32'h10,   32'h0,        DT_BYTE,  0, 32'h0,        1, 0, 32'h0000007F, 32'h8000FF7F});
        vecs.push_back(vec_t'{"ld_sb13",  0, 1, 32'h13,   32'h0,        DT_BYTE,  0, 32'h0,        1, 0, 32'hFFFFFF80, 32'h8000FF7F});
        vecs.push_back(vec_t'{"ld_sh10",  0, 1, 32'h10,   32'h0,        DT_HALF,  0, 32'h0,        1, 0, 32'hFFFFFF7F, 32'h8000FF7F});
        vecs.push_back(vec_t'{"mis_ldh",  0, 1, 32'h13,   32'h0,        DT_HALF,  0, 32'h0,        0, 1, 32'h0,        32'h8000FF7F});
        vecs.push_back(vec_t'{"mis_ldw",  0, 1, 32'h12,   32'h0,        DT_WORD,  0, 32'h0,        0, 1, 32'h0,        32'h8000FF7F});
        vecs.push_back(vec_t'{"mis_stw",  1, 0, 32'h22,   32'hFFFFFFFF, DT_WORD,  1, 32'h12345678, 0, 1, 32'h0,        32'h12345678});
        vecs.push_back(vec_t'{"both_st",  1, 1, 32'h20,   32'hCAFEF00D, DT_WORD,  0, 32'h0,        0, 0, 32'h0,        32'hCAFEF00D});
        vecs.push_back(vec_t'{"st_half",  1, 1, 32'h32,   32'h1234BEEF, DT_UHALF, 1, 32'hAAAAAAAA, 1, 0, 32'h0,        32'hBEEFAAAA});
        vecs.push_back(vec_t'{"st_byte3", 1, 1, 32'h37,   32'h0000005A, DT_BYTE,  1, 32'h00000000, 1, 0, 32'h0,        32'h5A000000});
        vecs.push_back(vec_t'{"wrap_st",  1, 0, 32'h4010, 32'h0F0F0F0F, DT_WORD,  0, 32'h0,        0, 0, 32'h0,        32'h0F0F0F0F});

        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst stall",  {31'h0, stall},   32'h0);
        check("rst valid",  {31'h0, r_valid}, 32'h0);
        check("rst ram_en", {31'h0, ram_en},  32'h0);
        check("rst rdata",  r_data,           32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(AW'(3), 32'h33333333);
        preload(AW'(5), 32'h55555555);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        check("nbr word3", mem[3], 32'h33333333);
        check("nbr word5", mem[5], 32'h55555555);

        // Back-to-back word stores are accepted on consecutive cycles.
        @(posedge clk); #1;
        w_en = 1'b1; dtype = DT_WORD; w_addr = 32'h40; w_data = 32'h00000001;
        @(posedge clk); #1;
        w_addr = 32'h44; w_data = 32'h00000002;
        @(negedge clk);
        check("b2b we2", {31'h0, ram_we}, 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        check("b2b word16", mem[16], 32'h00000001);
        check("b2b word17", mem[17], 32'h00000002);

        // Reset asserted during RMW_MERGE abandons the write.
        preload(AW'(6), 32'h11111111);
        @(posedge clk); #1;
        begin
            int unsigned wr_before;
            wr_before = wr_count;
            w_en = 1'b1; r_en = 1'b1; dtype = DT_BYTE; w_addr = 32'h18; w_data = 32'h00000022;
            @(negedge clk);
            check("rmwrst stall", {31'h0, stall}, 32'h1);
            @(posedge clk); #1;
            idle_inputs();
            #1 rst_n = 1'b0;
            #1;
            check("rmwrst ram_en", {31'h0, ram_en},  32'h0);
            check("rmwrst ram_we", {31'h0, ram_we},  32'h0);
            check("rmwrst wdata",  ram_wdata,        32'h0);
            check("rmwrst valid",  {31'h0, r_valid}, 32'h0);
            @(posedge clk); #1;
            check("rmwrst mem", mem[6], 32'h11111111);
            check("rmwrst writes", wr_count - wr_before, 32'd0);
            rst_n = 1'b1;
            @(negedge clk);
            check("rmwrst idle", {31'h0, ram_en}, 32'h0);
        end
        run_vec(vec_t'{"post_rst", 0, 1, 32'h18, 32'h0, DT_WORD, 0, 32'h0, 1, 0, 32'h11111111, 32'h11111111});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
